// File: rtl/cw_rx_decoder.sv
// cw_rx_decoder: Morse receive decoder that debounces and times the key envelope, then emits symbols and word gaps.
module cw_rx_decoder #(
  parameter int TICK_DIV = 8192,
  parameter int UNIT = 8,
  parameter int DEB = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic [2:0] sym_len,
  output logic [5:0] sym_bits,
  output logic       word_gap,
  output logic       sym_drop,
  output logic       key_db
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(7 * UNIT + 1);
  localparam int DW = $clog2(DEB + 1);
  localparam logic [CW-1:0] SAT = CW'(7 * UNIT);
  localparam logic [CW-1:0] CHAR_T = CW'(2 * UNIT);
  localparam logic [CW-1:0] WORD_T = CW'(5 * UNIT);
  typedef enum logic [1:0] {IDLE, MARK, SPACE_IN, SPACE_WORD} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] pre;
  logic tick, s1, s2, flip, rise, fall, load, wg_hit, ovf;
  logic [DW-1:0] deb_cnt;
  logic [CW-1:0] mark_cnt, space_cnt, mark_inc, space_inc;
  logic [2:0] elem_cnt;
  logic [5:0] elem_bits;
  assign tick = pre == PW'(TICK_DIV - 1);
  assign flip = tick && (s2 != key_db) && (deb_cnt == DW'(DEB - 1));
  assign rise = flip && !key_db;
  assign fall = flip && key_db;
  assign mark_inc = (mark_cnt == SAT) ? SAT : mark_cnt + 1'b1;
  assign space_inc = (space_cnt == SAT) ? SAT : space_cnt + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // A rise on the same tick as a threshold still honours the threshold, then re-enters MARK
  always_comb begin
    state_nxt = state;
    load = 1'b0;
    wg_hit = 1'b0;
    if (tick)
      case (state)
        IDLE: state_nxt = rise ? MARK : IDLE;
        MARK: state_nxt = fall ? SPACE_IN : MARK;
        SPACE_IN: begin
          load = space_inc == CHAR_T;
          state_nxt = rise ? MARK : load ? SPACE_WORD : SPACE_IN;
        end
        default: begin
          wg_hit = space_inc == WORD_T;
          state_nxt = rise ? MARK : wg_hit ? IDLE : SPACE_WORD;
        end
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      pre <= '0;
      deb_cnt <= '0;
      key_db <= 1'b0;
      mark_cnt <= '0;
      space_cnt <= '0;
      elem_cnt <= '0;
      elem_bits <= '0;
      ovf <= 1'b0;
      sym_valid <= 1'b0;
      sym_len <= '0;
      sym_bits <= '0;
      sym_drop <= 1'b0;
      word_gap <= 1'b0;
    end else begin
      s1 <= key_in;
      s2 <= s1;
      pre <= tick ? '0 : pre + 1'b1;
      word_gap <= wg_hit;
      if (tick) begin
        deb_cnt <= (s2 == key_db || flip) ? '0 : deb_cnt + 1'b1;
        key_db <= flip ? s2 : key_db;
        mark_cnt <= rise ? '0 : key_db ? mark_inc : mark_cnt;
        space_cnt <= fall ? '0 : key_db ? space_cnt : space_inc;
      end
      if (fall) begin
        if (elem_cnt < 3'd6) begin
          elem_bits[elem_cnt] <= mark_inc >= CHAR_T;
          elem_cnt <= elem_cnt + 1'b1;
        end else ovf <= 1'b1;
      end
      if (load) begin
        elem_cnt <= '0;
        elem_bits <= '0;
        ovf <= 1'b0;
      end
      // a full, unaccepted holding register keeps its symbol and discards the new one
      if (load && !(sym_valid && !sym_ready)) begin
        sym_valid <= 1'b1;
        sym_len <= ovf ? 3'd7 : elem_cnt;
        sym_bits <= elem_bits;
      end else if (load) sym_drop <= 1'b1;
      else if (sym_valid && sym_ready) sym_valid <= 1'b0;
    end
endmodule

// File: tb/tb_cw_rx_decoder.sv
// tb_cw_rx_decoder: directed and randomized Morse sequences checked against a symbol-level model.
module tb_cw_rx_decoder;
  localparam int TD = 4;
  localparam int U = 4;
  localparam int DB = 2;
  localparam int UC = U * TD;
  logic clk = 1'b0, rst_n = 1'b0, key_in = 1'b0, sym_ready = 1'b1;
  logic sym_valid, word_gap, sym_drop, key_db;
  logic [2:0] sym_len;
  logic [5:0] sym_bits;
  int total = 0, bad = 0;
  int cyc = 0, wg_cnt = 0, kr_cnt = 0, kf_time = 0, sv_time = 0, wg_time = 0;
  logic pk = 1'b0, pv = 1'b0;
  logic [8:0] got[$];
  logic [8:0] exp_q[$];
  int rd = 0;
  cw_rx_decoder #(.TICK_DIV(TD), .UNIT(U), .DEB(DB)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_len(sym_len), .sym_bits(sym_bits), .word_gap(word_gap), .sym_drop(sym_drop), .key_db(key_db)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (sym_valid && sym_ready) got.push_back({sym_len, sym_bits});
      if (word_gap) begin
        wg_cnt++;
        wg_time = cyc;
      end
      if (key_db && !pk) kr_cnt++;
      if (!key_db && pk) kf_time = cyc;
      if (sym_valid && !pv) sv_time = cyc;
    end
    pk = key_db;
    pv = sym_valid;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [8:0] model(input int n, input logic [7:0] pat);
    logic [5:0] b;
    b = '0;
    for (int i = 0; i < n && i < 6; i++) b[i] = pat[i];
    return {(n > 6) ? 3'd7 : 3'(n), b};
  endfunction
  task automatic hold(input logic v, input int n);
    key_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input int n, input logic [7:0] pat, input int gap_clk);
    for (int i = 0; i < n; i++) begin
      hold(1'b1, (pat[i] ? 3 : 1) * UC);
      hold(1'b0, (i == n - 1) ? gap_clk : UC);
    end
  endtask
  task automatic chk_syms(input string tag);
    int n;
    n = got.size() - rd;
    chk({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) chk({tag, "_sym"}, got[rd + i], exp_q[i]);
    rd = got.size();
    exp_q.delete();
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, sym_valid, 0);
    chk({tag, "_len"}, sym_len, 0);
    chk({tag, "_bits"}, sym_bits, 0);
    chk({tag, "_wgap"}, word_gap, 0);
    chk({tag, "_drop"}, sym_drop, 0);
    chk({tag, "_keydb"}, key_db, 0);
  endtask
  initial begin
    int wg0, kr0, ew, n, wordy;
    logic [7:0] pat;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    hold(1'b0, 4 * UC);
    wg0 = wg_cnt; kr0 = kr_cnt;
    send(2, 8'b10, 200);
    exp_q.push_back(model(2, 8'b10));
    chk_syms("A");
    chk("A_wgap", wg_cnt - wg0, 1);
    chk("A_marks", kr_cnt - kr0, 2);
    chk("A_sym_latency", sv_time - kf_time, 2 * UC);
    chk("A_wgap_latency", wg_time - kf_time, 5 * UC);
    wg0 = wg_cnt;
    send(3, 8'b000, 3 * UC);
    send(3, 8'b111, 8 * UC);
    exp_q.push_back(model(3, 8'b000));
    exp_q.push_back(model(3, 8'b111));
    chk_syms("SO");
    chk("SO_wgap", wg_cnt - wg0, 1);
    wg0 = wg_cnt; kr0 = kr_cnt;
    hold(1'b1, TD);
    hold(1'b0, 50 * TD);
    chk("glitch_marks", kr_cnt - kr0, 0);
    chk("glitch_keydb", key_db, 0);
    chk("glitch_wgap", wg_cnt - wg0, 0);
    chk_syms("glitch");
    wg0 = wg_cnt;
    send(7, 8'b0, 3 * UC);
    send(2, 8'b01, 8 * UC);
    exp_q.push_back(model(7, 8'b0));
    exp_q.push_back(model(2, 8'b01));
    chk_syms("ovf");
    chk("ovf_wgap", wg_cnt - wg0, 1);
    wg0 = wg_cnt; ew = 0;
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 7);
      pat = 8'($urandom);
      wordy = (k == 7) ? 1 : $urandom_range(0, 1);
      send(n, pat, (wordy != 0 ? 8 : 3) * UC);
      exp_q.push_back(model(n, pat));
      ew += wordy;
    end
    chk_syms("rand");
    chk("rand_wgap", wg_cnt - wg0, ew);
    chk("rand_drop", sym_drop, 0);
    sym_ready = 1'b0;
    send(1, 8'b0, 3 * UC);
    send(1, 8'b1, 8 * UC);
    chk("drop_valid", sym_valid, 1);
    chk("drop_len", sym_len, 1);
    chk("drop_bits", sym_bits, 0);
    chk("drop_flag", sym_drop, 1);
    sym_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drop_cleared", sym_valid, 0);
    exp_q.push_back(model(1, 8'b0));
    chk_syms("drop");
    hold(1'b0, 4 * UC);
    chk("drop_sticky", sym_drop, 1);
    hold(1'b1, UC);
    hold(1'b0, UC);
    hold(1'b1, UC);
    hold(1'b0, UC);
    hold(1'b1, 8);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("midreset");
    hold(1'b0, 2 * UC);
    rst_n = 1'b1;
    hold(1'b0, 2 * UC);
    send(1, 8'b1, 8 * UC);
    exp_q.push_back(model(1, 8'b1));
    chk_syms("rst");
    chk("rst_drop", sym_drop, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
